// File: rtl/i2s_stereo_serializer.sv
// Philips I2S serialiser: PCM frames arrive over valid/ready, are buffered in a small FIFO
// and are shifted out MSB first with a one-bit delay, all on the audio MCLK.
module i2s_stereo_serializer #(
  parameter int SAMPLE_WIDTH   = 16,
  parameter int SLOT_WIDTH     = 32,
  parameter int BCLK_DIV       = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter bit MONO           = 1'b0,
  parameter int UNDERRUN_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_left,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic                           mute,
  output logic                           lrck,
  output logic                           dac,
  output logic                           bit_tick,
  output logic [UNDERRUN_WIDTH-1:0]      underrun_count
);
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int DIV_W      = $clog2(BCLK_DIV);
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int SIDX_W     = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_WIDTH);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  function automatic logic [UNDERRUN_WIDTH-1:0] sat_inc(input logic [UNDERRUN_WIDTH-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  // Slot position 0 is the Philips delay bit; positions past the sample are padding.
  function automatic logic slot_bit(input logic signed [SAMPLE_WIDTH-1:0] s,
                                    input logic [BIT_W-1:0] p);
    logic [SIDX_W-1:0] idx;
    idx      = SIDX_W'(SAMPLE_WIDTH - int'(p));
    slot_bit = (p != '0) && (int'(p) <= SAMPLE_WIDTH) && s[idx];
  endfunction

  logic [DIV_W-1:0] div_cnt_p0;
  logic [BIT_W-1:0] bit_cnt_p0;
  logic [BIT_W-1:0] bit_nxt;
  logic [BIT_W-1:0] slot_pos;
  logic             div_wrap;
  logic             fetch;
  logic             lrck_nxt;

  logic signed [SAMPLE_WIDTH-1:0] fifo_left  [FIFO_DEPTH];
  logic signed [SAMPLE_WIDTH-1:0] fifo_right [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  logic signed [SAMPLE_WIDTH-1:0] frame_left_p0;
  logic signed [SAMPLE_WIDTH-1:0] frame_right_p0;
  logic lrck_p1;
  logic dac_p1;
  logic tick_p1;

  assign div_wrap = (div_cnt_p0 == DIV_LAST);
  assign fetch    = div_wrap && (bit_cnt_p0 == BIT_LAST);
  assign bit_nxt  = (bit_cnt_p0 == BIT_LAST) ? '0 : bit_cnt_p0 + 1'b1;
  assign lrck_nxt = (bit_nxt >= SLOT_LEN);
  assign slot_pos = lrck_nxt ? bit_nxt - SLOT_LEN : bit_nxt;

  assign fifo_full    = (fifo_cnt == FIFO_FULL);
  assign fifo_empty   = (fifo_cnt == '0);
  assign sample_ready = !fifo_full && !reset;
  assign push         = sample_valid && sample_ready;
  assign pop          = fetch && !fifo_empty;

  // Stage 0: FIFO storage, frame register and bit/divider counters
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_left[wr_ptr]  <= sample_left;
      fifo_right[wr_ptr] <= MONO ? sample_left : sample_right;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // An empty FIFO at fetch leaves the previous frame in place so it simply repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_left_p0  <= '0;
      frame_right_p0 <= '0;
      underrun_count <= '0;
    end else if (fetch) begin
      if (pop) begin
        frame_left_p0  <= fifo_left[rd_ptr];
        frame_right_p0 <= fifo_right[rd_ptr];
      end else begin
        underrun_count <= sat_inc(underrun_count);
      end
    end
  end

  // Stage 1: serial outputs, reloaded on the edge where the divider returns to 0
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_p0 <= '0;
      bit_cnt_p0 <= '0;
      lrck_p1    <= 1'b0;
      dac_p1     <= 1'b0;
      tick_p1    <= 1'b0;
    end else begin
      div_cnt_p0 <= div_wrap ? '0 : div_cnt_p0 + 1'b1;
      tick_p1    <= div_wrap;
      if (div_wrap) begin
        bit_cnt_p0 <= bit_nxt;
        lrck_p1    <= lrck_nxt;
        dac_p1     <= !mute && slot_bit(lrck_nxt ? frame_right_p0 : frame_left_p0, slot_pos);
      end
    end
  end

  assign lrck     = lrck_p1;
  assign dac      = dac_p1;
  assign bit_tick = tick_p1;

endmodule

// File: tb/tb_i2s_stereo_serializer.sv
// Bench for i2s_stereo_serializer: default, mono and short-slot instances share one stimulus
// stream; each is compared every cycle against a time-based frame/queue reference model.
module tb_i2s_stereo_serializer;
  localparam int NI = 3;
  localparam logic [63:0] LRCK_PAT = {32'h0000_0000, 32'hFFFF_FFFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset        = 1'b1;
  logic        sample_valid = 1'b0;
  logic        mute         = 1'b0;
  logic [15:0] sample_left  = '0;
  logic [15:0] sample_right = '0;

  logic       ready_v [NI];
  logic       lrck_v  [NI];
  logic       dac_v   [NI];
  logic       tick_v  [NI];
  logic [7:0] uc0;
  logic [7:0] uc1;
  logic [2:0] uc2;

  i2s_stereo_serializer u_dut0 (
    .clk(clk), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready_v[0]), .mute(mute),
    .lrck(lrck_v[0]), .dac(dac_v[0]), .bit_tick(tick_v[0]), .underrun_count(uc0));

  i2s_stereo_serializer #(.MONO(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready_v[1]), .mute(mute),
    .lrck(lrck_v[1]), .dac(dac_v[1]), .bit_tick(tick_v[1]), .underrun_count(uc1));

  i2s_stereo_serializer #(.SLOT_WIDTH(24), .BCLK_DIV(2), .UNDERRUN_WIDTH(3)) u_dut2 (
    .clk(clk), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(ready_v[2]), .mute(mute),
    .lrck(lrck_v[2]), .dac(dac_v[2]), .bit_tick(tick_v[2]), .underrun_count(uc2));

  // Per-instance configuration
  int ps   [NI] = '{32, 32, 24};
  int pd   [NI] = '{4, 4, 2};
  bit pm   [NI] = '{1'b0, 1'b1, 1'b0};
  int pmax [NI] = '{255, 255, 7};

  // Reference model state: cycles since reset release, queued frames, current frame
  int          mt    [NI];
  int          mcnt  [NI];
  int          mhead [NI];
  int          muc   [NI];
  logic [15:0] mfl   [NI];
  logic [15:0] mfr   [NI];
  logic [15:0] mql   [NI][4];
  logic [15:0] mqr   [NI][4];
  logic        elrck [NI];
  logic        edac  [NI];
  logic        etick [NI];

  logic [63:0] capd [2];
  logic [63:0] capl [2];
  logic        acc0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_uc(input int i);
    case (i)
      0:       return uc0;
      1:       return uc1;
      default: return {5'b0, uc2};
    endcase
  endfunction

  task automatic model_clear(input int i);
    mt[i] = 0; mcnt[i] = 0; mhead[i] = 0; muc[i] = 0;
    mfl[i] = '0; mfr[i] = '0;
    elrck[i] = 1'b0; edac[i] = 1'b0; etick[i] = 1'b0;
  endtask

  // One clock edge of the reference: fetch on the last clk of a frame, then push, then time advances.
  task automatic model_edge(input int i, input logic push);
    int frame_clks, b, p, w;
    logic [15:0] s, sh;
    if (reset) begin
      model_clear(i);
      return;
    end
    frame_clks = 2 * ps[i] * pd[i];
    if ((mt[i] + 1) % frame_clks == 0) begin
      if (mcnt[i] > 0) begin
        mfl[i]   = mql[i][mhead[i]];
        mfr[i]   = mqr[i][mhead[i]];
        mhead[i] = (mhead[i] + 1) % 4;
        mcnt[i]--;
      end else if (muc[i] < pmax[i]) begin
        muc[i]++;
      end
    end
    if (push) begin
      w = (mhead[i] + mcnt[i]) % 4;
      mql[i][w] = sample_left;
      mqr[i][w] = pm[i] ? sample_left : sample_right;
      mcnt[i]++;
    end
    mt[i]++;
    etick[i] = (mt[i] % pd[i] == 0);
    if (etick[i]) begin
      b        = (mt[i] / pd[i]) % (2 * ps[i]);
      elrck[i] = (b >= ps[i]);
      p        = b % ps[i];
      s        = elrck[i] ? mfr[i] : mfl[i];
      edac[i]  = 1'b0;
      if (!mute && p >= 1 && p <= 16) begin
        sh      = s >> (16 - p);
        edac[i] = sh[0];
      end
    end
  endtask

  // Inputs are already driven; check ready before the edge and all outputs 1 ns after it.
  task automatic cycle();
    logic push [NI];
    logic er;
    #1;
    for (int i = 0; i < NI; i++) begin
      er = !reset && (mcnt[i] < 4);
      chk($sformatf("i%0d.ready", i), 64'(ready_v[i]), 64'(er));
      push[i] = sample_valid && er;
    end
    acc0 = sample_valid && ready_v[0];
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i, push[i]);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d.lrck", i), 64'(lrck_v[i]), 64'(elrck[i]));
      chk($sformatf("i%0d.dac", i), 64'(dac_v[i]), 64'(edac[i]));
      chk($sformatf("i%0d.bit_tick", i), 64'(tick_v[i]), 64'(etick[i]));
      chk($sformatf("i%0d.underrun", i), 64'(dut_uc(i)), 64'(muc[i]));
    end
    for (int i = 0; i < 2; i++) begin
      if (mt[i] % 4 == 0) begin
        capd[i] = {capd[i][62:0], dac_v[i]};
        capl[i] = {capl[i][62:0], lrck_v[i]};
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; sample_valid = 1'b0; mute = 1'b0;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic run_to(input int i, input int target);
    int c;
    c = 0;
    while (mt[i] != target && c < 5000) begin
      cycle();
      c++;
    end
    if (mt[i] != target) chk("run_to_timeout", 64'(mt[i]), 64'(target));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc;
    int acc_t [6];
    logic [15:0] bl [6];
    logic [15:0] br [6];

    for (int i = 0; i < NI; i++) model_clear(i);
    capd[0] = '0; capd[1] = '0; capl[0] = '0; capl[1] = '0;

    // Defaults: one frame during frame 0, then underruns repeating it
    do_reset(3);
    sample_left = 16'h8001; sample_right = 16'h7FFE; sample_valid = 1'b1;
    cycle();
    sample_valid = 1'b0;
    for (int c = 0; c < 1100 && mt[0] < 1030; c++) begin
      cycle();
      case (mt[0])
        256:  chk("A.uc_f0", 64'(uc0), 64'd0);
        512:  chk("A.uc_f1", 64'(uc0), 64'd1);
        768:  chk("A.uc_f2", 64'(uc0), 64'd2);
        1024: chk("A.uc_f3", 64'(uc0), 64'd3);
        default: ;
      endcase
      if (mt[0] % 256 == 252) begin
        chk("A.frame_dac", capd[0], (mt[0] < 256) ? 64'h0 : {32'h4000_8000, 32'h3FFF_0000});
        chk("A.frame_lrck", capl[0], LRCK_PAT);
      end
      case (mt[2])
        47:  chk("A.v24_lrck47", 64'(lrck_v[2]), 64'd0);
        48:  chk("A.v24_lrck48", 64'(lrck_v[2]), 64'd1);
        96:  chk("A.v24_lrck96", 64'(lrck_v[2]), 64'd0);
        144: chk("A.v24_lrck144", 64'(lrck_v[2]), 64'd1);
        default: ;
      endcase
    end
    chk("A.uc_saturate", 64'(uc2), 64'd7);

    // Backpressure: six distinct frames offered back to back
    do_reset(2);
    for (int k = 0; k < 6; k++) begin
      bl[k] = {4'(k + 1), 12'($urandom)};
      br[k] = {4'(k + 8), 12'($urandom)};
    end
    nacc = 0;
    for (int c = 0; c < 2000 && nacc < 6; c++) begin
      int pre;
      sample_left = bl[nacc]; sample_right = br[nacc]; sample_valid = 1'b1;
      pre = mt[0];
      cycle();
      if (acc0) begin
        acc_t[nacc] = pre;
        nacc++;
      end
    end
    sample_valid = 1'b0;
    chk("B.accepts", 64'(nacc), 64'd6);
    chk("B.acc4_time", 64'(acc_t[3]), 64'd3);
    chk("B.acc5_time", 64'(acc_t[4]), 64'd256);
    run_to(0, 1800);
    chk("B.no_loss", 64'(uc0), 64'd1);

    // Mono versus stereo on the same input
    do_reset(2);
    sample_left = 16'h1234; sample_right = 16'hFFFF; sample_valid = 1'b1;
    cycle();
    sample_valid = 1'b0;
    run_to(0, 508);
    chk("C.mono_dac", capd[1], {32'h091A_0000, 32'h091A_0000});
    chk("C.stereo_dac", capd[0], {32'h091A_0000, 32'h7FFF_8000});

    // Mute from the middle of left bit 8; FIFO keeps popping underneath
    do_reset(2);
    sample_left = 16'hFFFF; sample_right = 16'hFFFF; sample_valid = 1'b1;
    cycle();
    sample_left = 16'hAAAA; sample_right = 16'h5555;
    cycle();
    sample_valid = 1'b0;
    run_to(0, 290);
    mute = 1'b1;
    run_to(0, 508);
    chk("D.mute_dac", capd[0], {32'h7F80_0000, 32'h0});
    chk("D.mute_lrck", capl[0], LRCK_PAT);
    run_to(0, 512);
    chk("D.mute_pop", 64'(uc0), 64'd0);
    mute = 1'b0;
    run_to(0, 764);
    chk("D.after_mute", capd[0], {32'h5555_0000, 32'h2AAA_8000});

    // Reset at bit_cnt 40 with three frames still queued
    do_reset(2);
    sample_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample_left = 16'($urandom); sample_right = 16'($urandom);
      cycle();
    end
    sample_valid = 1'b0;
    run_to(0, 416);
    reset = 1'b1;
    cycle();
    chk("E.lrck", 64'(lrck_v[0]), 64'd0);
    chk("E.dac", 64'(dac_v[0]), 64'd0);
    chk("E.uc", 64'(uc0), 64'd0);
    reset = 1'b0;
    #1;
    chk("E.ready", 64'(ready_v[0]), 64'd1);
    run_to(0, 256);
    chk("E.flushed", 64'(uc0), 64'd1);

    // Random traffic, mute toggles and occasional resets
    for (int c = 0; c < 5000; c++) begin
      reset        = ($urandom_range(0, 1499) == 0);
      sample_valid = ($urandom_range(0, 2) == 0);
      sample_left  = 16'($urandom);
      sample_right = 16'($urandom);
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      cycle();
    end
    reset = 1'b0; sample_valid = 1'b0; mute = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
